// File: rtl/draw_obstacle_pkg.sv
// rtl/draw_obstacle_pkg.sv - shared obstacle FSM encoding, arena constants and position helpers
package draw_obstacle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } obstacle_state_t;

  // One axis of obstacle motion: position plus direction (1 = increasing).
  typedef struct packed {
    logic [11:0] pos;
    logic        up;
  } axis_t;

  localparam int          ARENA_TOP_V_LINE    = 367;
  localparam int          ARENA_BOTTOM_V_LINE = 667;
  localparam int          ARENA_LEFT_H_LINE   = 361;
  localparam int          ARENA_RIGHT_H_LINE  = 661;
  localparam int          OBSTACLE_SIZE       = 40;
  localparam int          OBSTACLE_STEP       = 2;
  localparam logic [11:0] OBSTACLE_COLOR      = 12'hF00;

  // pos lies in [start, start+size); the sum is 13 bits so the upper bound cannot wrap.
  function automatic logic in_span(input logic [11:0] pos, input logic [11:0] start,
                                   input logic [11:0] size);
    return (pos >= start) && ({1'b0, pos} < ({1'b0, start} + {1'b0, size}));
  endfunction

  // Advance one axis by step, clamping to [lo, hi] and reversing when a bound is reached.
  // Bounds are tested before the add/subtract is used, so the 12-bit result never wraps.
  function automatic axis_t step_axis(input logic [11:0] pos, input logic up,
                                      input logic [11:0] lo, input logic [11:0] hi,
                                      input logic [11:0] step);
    axis_t r;
    r.pos = pos;
    r.up  = up;
    if (up) begin
      if (({1'b0, pos} + {1'b0, step}) >= {1'b0, hi}) begin
        r.pos = hi;
        r.up  = 1'b0;
      end else begin
        r.pos = pos + step;
      end
    end else begin
      if ({1'b0, pos} <= ({1'b0, lo} + {1'b0, step})) begin
        r.pos = lo;
        r.up  = 1'b1;
      end else begin
        r.pos = pos - step;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/obstacle_mover.sv
// rtl/obstacle_mover.sv - obstacle FSM, bouncing position, direction and hit flag
module obstacle_mover
  import draw_obstacle_pkg::*;
#(
  parameter int TOP_V_LINE    = ARENA_TOP_V_LINE,
  parameter int BOTTOM_V_LINE = ARENA_BOTTOM_V_LINE,
  parameter int LEFT_H_LINE   = ARENA_LEFT_H_LINE,
  parameter int RIGHT_H_LINE  = ARENA_RIGHT_H_LINE,
  parameter int SIZE          = OBSTACLE_SIZE,
  parameter int STEP          = OBSTACLE_STEP
)(
  input  logic            pclk,
  input  logic            rst,
  input  logic            tick,
  input  logic            game_on,
  input  logic [11:0]     mouse_x,
  input  logic [11:0]     mouse_y,
  output logic [11:0]     x_pos,
  output logic [11:0]     y_pos,
  output obstacle_state_t state,
  output logic            hit
);

  localparam logic [11:0] X_MIN  = 12'(LEFT_H_LINE);
  localparam logic [11:0] X_MAX  = 12'(RIGHT_H_LINE - SIZE);
  localparam logic [11:0] Y_MIN  = 12'(TOP_V_LINE);
  localparam logic [11:0] Y_MAX  = 12'(BOTTOM_V_LINE - SIZE);
  localparam logic [11:0] SIZE_W = 12'(SIZE);
  localparam logic [11:0] STEP_W = 12'(STEP);

  obstacle_state_t state_n;
  logic [11:0]     x_n, y_n;
  logic            dx, dy, dx_n, dy_n;
  axis_t           x_step, y_step;

  assign x_step = step_axis(x_pos, dx, X_MIN, X_MAX, STEP_W);
  assign y_step = step_axis(y_pos, dy, Y_MIN, Y_MAX, STEP_W);
  assign hit    = (state == ST_HIT);

  // State, position and direction registers; reset parks the obstacle top-left moving down-right.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      x_pos <= X_MIN;
      y_pos <= Y_MIN;
      dx    <= 1'b1;
      dy    <= 1'b1;
    end else begin
      state <= state_n;
      x_pos <= x_n;
      y_pos <= y_n;
      dx    <= dx_n;
      dy    <= dy_n;
    end
  end

  // Next state: game_on low wins over everything, otherwise act only on a frame tick.
  always_comb begin
    state_n = state;
    x_n     = x_pos;
    y_n     = y_pos;
    dx_n    = dx;
    dy_n    = dy;
    if (!game_on) begin
      state_n = ST_IDLE;
      x_n     = X_MIN;
      y_n     = Y_MIN;
      dx_n    = 1'b1;
      dy_n    = 1'b1;
    end else if (tick) begin
      case (state)
        ST_IDLE: state_n = ST_RUN;
        ST_RUN: begin
          if (in_span(mouse_x, x_pos, SIZE_W) && in_span(mouse_y, y_pos, SIZE_W)) begin
            state_n = ST_HIT;
          end else begin
            x_n  = x_step.pos;
            dx_n = x_step.up;
            y_n  = y_step.pos;
            dy_n = y_step.up;
          end
        end
        default: state_n = state;
      endcase
    end
  end

endmodule

// File: rtl/draw_obstacle.sv
// rtl/draw_obstacle.sv - one-cycle pixel pipeline compositing a bouncing obstacle over rgb_in
module draw_obstacle
  import draw_obstacle_pkg::*;
#(
  parameter int          TOP_V_LINE    = ARENA_TOP_V_LINE,
  parameter int          BOTTOM_V_LINE = ARENA_BOTTOM_V_LINE,
  parameter int          LEFT_H_LINE   = ARENA_LEFT_H_LINE,
  parameter int          RIGHT_H_LINE  = ARENA_RIGHT_H_LINE,
  parameter int          SIZE          = OBSTACLE_SIZE,
  parameter int          STEP          = OBSTACLE_STEP,
  parameter logic [11:0] COLOR         = OBSTACLE_COLOR
)(
  input  logic        pclk,
  input  logic        rst,
  input  logic        game_on,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        hit
);

  localparam logic [11:0] SIZE_W = 12'(SIZE);

  logic            vblnk_prev;
  logic            tick;
  logic            draw;
  logic [11:0]     rgb_next;
  logic [11:0]     x_pos, y_pos;
  obstacle_state_t state;

  assign tick = vblnk_in & ~vblnk_prev;

  obstacle_mover #(
    .TOP_V_LINE    (TOP_V_LINE),
    .BOTTOM_V_LINE (BOTTOM_V_LINE),
    .LEFT_H_LINE   (LEFT_H_LINE),
    .RIGHT_H_LINE  (RIGHT_H_LINE),
    .SIZE          (SIZE),
    .STEP          (STEP)
  ) u_mover (
    .pclk    (pclk),
    .rst     (rst),
    .tick    (tick),
    .game_on (game_on),
    .mouse_x (xpos),
    .mouse_y (ypos),
    .x_pos   (x_pos),
    .y_pos   (y_pos),
    .state   (state),
    .hit     (hit)
  );

  // Pixel select: blanking forces black, otherwise obstacle colour inside its square.
  always_comb begin
    draw     = (state != ST_IDLE) && in_span(hcount_in, x_pos, SIZE_W)
               && in_span(vcount_in, y_pos, SIZE_W);
    rgb_next = rgb_in;
    if (hblnk_in || vblnk_in) begin
      rgb_next = 12'h000;
    end else if (draw) begin
      rgb_next = COLOR;
    end
  end

  // One-cycle delay of timing signals and composited pixel; vblnk_prev feeds frame-tick detection.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_out <= 12'd0;
      vcount_out <= 12'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'h000;
      vblnk_prev <= 1'b0;
    end else begin
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      hblnk_out  <= hblnk_in;
      vblnk_out  <= vblnk_in;
      rgb_out    <= rgb_next;
      vblnk_prev <= vblnk_in;
    end
  end

endmodule

// File: tb/tb_draw_obstacle.sv
// tb/tb_draw_obstacle.sv - randomized and directed self-checking bench for draw_obstacle
module tb_draw_obstacle;

  localparam int          LEFT   = 361;
  localparam int          RIGHT  = 661;
  localparam int          TOP    = 367;
  localparam int          BOTTOM = 667;
  localparam int          S      = 40;
  localparam int          STEP   = 2;
  localparam int          XMAX   = RIGHT - S;
  localparam int          YMAX   = BOTTOM - S;
  localparam logic [11:0] COLOR  = 12'hF00;
  localparam logic [11:0] BG     = 12'h0A5;

  logic        pclk, rst, game_on;
  logic [11:0] hcount_in, vcount_in, rgb_in, xpos, ypos;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out, hit;

  draw_obstacle dut (
    .pclk(pclk), .rst(rst), .game_on(game_on),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .hit(hit)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int          checks = 0;
  int          errors = 0;
  int          m_st;            // 0 idle, 1 run, 2 hit
  int          m_x, m_y, m_dx, m_dy;
  logic        vb_last;
  logic [11:0] exp_rgb;

  task automatic model_reset();
    m_st = 0; m_x = LEFT; m_y = TOP; m_dx = 1; m_dy = 1;
  endtask

  function automatic logic [11:0] model_pixel();
    int h, v;
    h = int'(hcount_in);
    v = int'(vcount_in);
    if (hblnk_in || vblnk_in) return 12'h000;
    if (m_st != 0 && h >= m_x && h < m_x + S && v >= m_y && v < m_y + S) return COLOR;
    return rgb_in;
  endfunction

  task automatic model_clock(input logic t);
    int nx, ny;
    if (!game_on) begin
      model_reset();
    end else if (t) begin
      if (m_st == 0) begin
        m_st = 1;
      end else if (m_st == 1) begin
        if (int'(xpos) >= m_x && int'(xpos) < m_x + S &&
            int'(ypos) >= m_y && int'(ypos) < m_y + S) begin
          m_st = 2;
        end else begin
          nx = m_x + m_dx * STEP;
          ny = m_y + m_dy * STEP;
          if (nx >= XMAX) begin m_x = XMAX; m_dx = -1; end
          else if (nx <= LEFT) begin m_x = LEFT; m_dx = 1; end
          else m_x = nx;
          if (ny >= YMAX) begin m_y = YMAX; m_dy = -1; end
          else if (ny <= TOP) begin m_y = TOP; m_dy = 1; end
          else m_y = ny;
        end
      end
    end
  endtask

  // One pclk edge with inputs as currently driven; model follows the same edge.
  task automatic cycle();
    logic t;
    t = vblnk_in && !vb_last;
    exp_rgb = rst ? model_pixel() : 12'h000;
    @(posedge pclk); #1;
    if (!rst) begin
      model_reset();
      vb_last = 1'b0;
    end else begin
      vb_last = vblnk_in;
      model_clock(t);
    end
  endtask

  task automatic tick();
    vblnk_in = 1'b1; hblnk_in = 1'b1; cycle();
    vblnk_in = 1'b0; hblnk_in = 1'b0; cycle();
  endtask

  task automatic probe(input int h, input int v);
    hcount_in = 12'(h); vcount_in = 12'(v); rgb_in = BG; cycle();
  endtask

  task automatic go_idle();
    hblnk_in = 1'b0; vblnk_in = 1'b0; xpos = 12'd0; ypos = 12'd0;
    game_on = 1'b0; cycle();
    game_on = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      game_on = 1'b1; hcount_in = 12'($urandom); vcount_in = 12'($urandom);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      hblnk_in = 1'($urandom); vblnk_in = 1'($urandom); rgb_in = 12'($urandom);
      cycle();
    end
    checks++; if ({hcount_out, vcount_out} !== 24'd0) begin errors++;
      $display("FAIL reset_counters: got %h/%h expected 0", hcount_out, vcount_out); end
    checks++; if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== 4'd0) begin errors++;
      $display("FAIL reset_strobes: got %b expected 0000", {hsync_out, vsync_out, hblnk_out, vblnk_out}); end
    checks++; if (rgb_out !== 12'h000) begin errors++;
      $display("FAIL reset_rgb: got %h expected 000", rgb_out); end
    checks++; if (hit !== 1'b0) begin errors++;
      $display("FAIL reset_hit: got %b expected 0", hit); end
    vblnk_in = 1'b0; hblnk_in = 1'b0; game_on = 1'b0;
    rst = 1'b1;
    hcount_in = 12'h123; cycle();
    hcount_in = 12'h456;
    checks++; if (hcount_out !== 12'h123) begin errors++;
      $display("FAIL release_delay1: got %h expected 123", hcount_out); end
    cycle();
    checks++; if (hcount_out !== 12'h456) begin errors++;
      $display("FAIL release_delay2: got %h expected 456", hcount_out); end
  endtask

  task automatic test_timing();
    logic [11:0] h, v, c;
    logic [3:0]  st;
    game_on = 1'b0;
    for (int i = 0; i < 8; i++) begin
      h = 12'($urandom); v = 12'($urandom); c = 12'($urandom); st = 4'($urandom);
      hcount_in = h; vcount_in = v; rgb_in = c;
      {hsync_in, vsync_in, hblnk_in, vblnk_in} = st;
      cycle();
      checks++; if (hcount_out !== h || vcount_out !== v) begin errors++;
        $display("FAIL timing_counters: got %h/%h expected %h/%h", hcount_out, vcount_out, h, v); end
      checks++; if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== st) begin errors++;
        $display("FAIL timing_strobes: got %b expected %b", {hsync_out, vsync_out, hblnk_out, vblnk_out}, st); end
      checks++; if (rgb_out !== exp_rgb) begin errors++;
        $display("FAIL timing_rgb: got %h expected %h", rgb_out, exp_rgb); end
    end
    hblnk_in = 1'b0; vblnk_in = 1'b0; cycle();
  endtask

  task automatic test_move();
    go_idle();
    probe(361, 367);
    checks++; if (rgb_out !== BG) begin errors++;
      $display("FAIL idle_not_drawn: got %h expected %h", rgb_out, BG); end
    tick();
    for (int i = 0; i < 3; i++) tick();
    probe(370, 375);
    checks++; if (rgb_out !== COLOR) begin errors++;
      $display("FAIL move_inside: got %h expected %h", rgb_out, COLOR); end
    probe(367, 373);
    checks++; if (rgb_out !== COLOR) begin errors++;
      $display("FAIL move_corner: got %h expected %h", rgb_out, COLOR); end
    probe(366, 373);
    checks++; if (rgb_out !== BG) begin errors++;
      $display("FAIL move_left_edge: got %h expected %h", rgb_out, BG); end
    probe(367, 372);
    checks++; if (rgb_out !== BG) begin errors++;
      $display("FAIL move_top_edge: got %h expected %h", rgb_out, BG); end
  endtask

  task automatic test_bounce();
    go_idle();
    tick();
    for (int i = 0; i < 129; i++) tick();   // x=619, y=625
    probe(619, 625);
    checks++; if (rgb_out !== COLOR) begin errors++;
      $display("FAIL pre_bounce_pos: got %h expected %h", rgb_out, COLOR); end
    tick();                                  // corner: x=621, y=627, both reverse
    probe(621, 627);
    checks++; if (rgb_out !== COLOR) begin errors++;
      $display("FAIL bounce_clamp: got %h expected %h", rgb_out, COLOR); end
    probe(620, 627);
    checks++; if (rgb_out !== BG) begin errors++;
      $display("FAIL bounce_left_edge: got %h expected %h", rgb_out, BG); end
    probe(660, 666);
    checks++; if (rgb_out !== COLOR) begin errors++;
      $display("FAIL bounce_far_corner: got %h expected %h", rgb_out, COLOR); end
    probe(661, 666);
    checks++; if (rgb_out !== BG) begin errors++;
      $display("FAIL bounce_right_edge: got %h expected %h", rgb_out, BG); end
    tick();
    probe(619, 625);
    checks++; if (rgb_out !== COLOR) begin errors++;
      $display("FAIL bounce_return: got %h expected %h", rgb_out, COLOR); end
    probe(660, 664);
    checks++; if (rgb_out !== BG) begin errors++;
      $display("FAIL bounce_return_edge: got %h expected %h", rgb_out, BG); end
  endtask

  task automatic test_hit();
    go_idle();
    tick(); tick();                          // obstacle at (363,369)
    xpos = 12'd380; ypos = 12'd385;
    tick();
    checks++; if (hit !== 1'b1) begin errors++;
      $display("FAIL hit_set: got %b expected 1", hit); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (hit !== 1'b1) begin errors++;
      $display("FAIL hit_held: got %b expected 1", hit); end
    probe(363, 369);
    checks++; if (rgb_out !== COLOR) begin errors++;
      $display("FAIL hit_frozen_corner: got %h expected %h", rgb_out, COLOR); end
    probe(362, 369);
    checks++; if (rgb_out !== BG) begin errors++;
      $display("FAIL hit_frozen_left: got %h expected %h", rgb_out, BG); end
    probe(402, 408);
    checks++; if (rgb_out !== COLOR) begin errors++;
      $display("FAIL hit_frozen_far: got %h expected %h", rgb_out, COLOR); end
    probe(403, 408);
    checks++; if (rgb_out !== BG) begin errors++;
      $display("FAIL hit_frozen_right: got %h expected %h", rgb_out, BG); end
  endtask

  task automatic test_game_off_priority();
    go_idle();
    tick(); tick();
    xpos = 12'd380; ypos = 12'd385;
    game_on = 1'b0;
    tick();
    checks++; if (hit !== 1'b0) begin errors++;
      $display("FAIL gameoff_hit: got %b expected 0", hit); end
    probe(363, 369);
    checks++; if (rgb_out !== BG) begin errors++;
      $display("FAIL gameoff_not_drawn: got %h expected %h", rgb_out, BG); end
    game_on = 1'b1;
    xpos = 12'd0; ypos = 12'd0;
  endtask

  task automatic test_blank();
    go_idle();
    tick(); tick();
    hblnk_in = 1'b1;
    probe(370, 375);
    checks++; if (rgb_out !== 12'h000) begin errors++;
      $display("FAIL hblnk_black: got %h expected 000", rgb_out); end
    hblnk_in = 1'b0;
    probe(370, 375);
    checks++; if (rgb_out !== COLOR) begin errors++;
      $display("FAIL unblank_drawn: got %h expected %h", rgb_out, COLOR); end
  endtask

  task automatic test_reset_mid_hit();
    go_idle();
    tick(); tick();
    xpos = 12'd380; ypos = 12'd385;
    tick();
    hcount_in = 12'd370; vcount_in = 12'd375; rgb_in = BG; cycle();
    checks++; if (hit !== 1'b1 || rgb_out !== COLOR) begin errors++;
      $display("FAIL midhit_pre: got hit=%b rgb=%h expected 1/%h", hit, rgb_out, COLOR); end
    rst = 1'b0;
    #2;
    checks++; if (hit !== 1'b0 || rgb_out !== 12'h000 || hcount_out !== 12'd0) begin errors++;
      $display("FAIL async_reset: got hit=%b rgb=%h hc=%h expected 0", hit, rgb_out, hcount_out); end
    cycle(); cycle();
    rst = 1'b1;
    xpos = 12'd0; ypos = 12'd0;
    cycle();
    tick();
    probe(361, 367);
    checks++; if (rgb_out !== COLOR || hit !== 1'b0) begin errors++;
      $display("FAIL post_reset_run: got rgb=%h hit=%b expected %h/0", rgb_out, hit, COLOR); end
  endtask

  task automatic test_random();
    go_idle();
    for (int i = 0; i < 300; i++) begin
      game_on = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 4) == 0) begin
        xpos = 12'(m_x + int'($urandom_range(0, S + 15)) - 8);
        ypos = 12'(m_y + int'($urandom_range(0, S + 15)) - 8);
      end else begin
        xpos = 12'($urandom); ypos = 12'($urandom);
      end
      tick();
      checks++; if (hit !== (m_st == 2)) begin errors++;
        $display("FAIL rand_hit[%0d]: got %b expected %b", i, hit, (m_st == 2)); end
      hblnk_in = ($urandom_range(0, 9) == 0);
      probe(m_x + int'($urandom_range(0, S + 3)) - 2, m_y + int'($urandom_range(0, S + 3)) - 2);
      checks++; if (rgb_out !== exp_rgb) begin errors++;
        $display("FAIL rand_pixel[%0d]: got %h expected %h", i, rgb_out, exp_rgb); end
      hblnk_in = 1'b0;
      probe(m_x + S - int'($urandom_range(0, 1)), m_y + S - int'($urandom_range(0, 1)));
      checks++; if (rgb_out !== exp_rgb) begin errors++;
        $display("FAIL rand_corner[%0d]: got %h expected %h", i, rgb_out, exp_rgb); end
    end
  endtask

  initial begin
    rst = 1'b0; game_on = 1'b0;
    hcount_in = '0; vcount_in = '0; rgb_in = '0; xpos = '0; ypos = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    vb_last = 1'b0; exp_rgb = '0;
    model_reset();
    test_reset();
    test_timing();
    test_move();
    test_bounce();
    test_hit();
    test_game_off_priority();
    test_blank();
    test_reset_mid_hit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
